// File: rtl/pwm_capture.sv
// PWM duty-cycle capture: recovers high/period tick counts averaged over 2^AVG_LOG2 periods.
// Define PWM_CAPTURE_GLITCH_FILTER_EN for a 3-tap majority filter on the sampled input.
module pwm_capture #(
   parameter int DIV      = 16,
   parameter int CNTW     = 9,
   parameter int AVG_LOG2 = 4,
   parameter int TIMEOUT  = 512
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     pwm_i,
   output logic [CNTW+AVG_LOG2-1:0] duty_o,
   output logic [CNTW-1:0]          period_o,
   output logic                     valid_o,
   output logic                     stuck_o,
   output logic                     stuck_level_o
);

   localparam int PW = $clog2(DIV);
   localparam int AW = CNTW + AVG_LOG2;
   localparam int NW = CNTW + 1;

   localparam logic [PW-1:0]       PRE_MAX = PW'(DIV - 1);
   localparam logic [CNTW-1:0]     CNT_MAX = '1;
   localparam logic [NW-1:0]       TO_VAL  = NW'(TIMEOUT);
   localparam logic [AVG_LOG2-1:0] N_LAST  = '1;

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      STUCK
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          sync_q, sync_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic                prev_q, prev_d;
   logic [CNTW-1:0]     period_cnt_q, period_cnt_d;
   logic [CNTW-1:0]     high_cnt_q, high_cnt_d;
   logic [NW-1:0]       no_edge_q, no_edge_d;
   logic [AW-1:0]       acc_q, acc_d;
   logic [AVG_LOG2-1:0] n_q, n_d;
   logic [AW-1:0]       duty_q, duty_d;
   logic [CNTW-1:0]     period_q, period_d;
   logic                valid_q, valid_d;
   logic                stuck_q, stuck_d;
   logic                level_q, level_d;

   logic                tick;
   logic                sample;
   logic                rise;
   logic                start;
   logic                close;
   logic                expire;
   logic [NW-1:0]       no_edge_inc;
   logic [AW-1:0]       acc_sum;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   logic [2:0] hist_q, hist_d;

   // Majority of the three previous tick samples; a lone odd sample never wins.
   always_comb begin
      hist_d = tick ? {hist_q[1:0], sync_q[1]} : hist_q;
      sample = (hist_q[0] & hist_q[1]) |
               (hist_q[0] & hist_q[2]) |
               (hist_q[1] & hist_q[2]);
   end

   always_ff @(posedge clk) begin
      if (!rstn) hist_q <= '0;
      else       hist_q <= hist_d;
   end
`else
   assign sample = sync_q[1];
`endif

   assign tick        = (presc_q == PRE_MAX);
   assign rise        = sample & ~prev_q;
   assign no_edge_inc = no_edge_q + 1'b1;
   assign acc_sum     = acc_q + AW'(high_cnt_q);

   always_comb begin
      sync_d       = {sync_q[0], pwm_i};
      presc_d      = tick ? '0 : presc_q + 1'b1;
      prev_d       = tick ? sample : prev_q;
      state_d      = state_q;
      period_cnt_d = period_cnt_q;
      high_cnt_d   = high_cnt_q;
      no_edge_d    = no_edge_q;
      acc_d        = acc_q;
      n_d          = n_q;
      duty_d       = duty_q;
      period_d     = period_q;
      valid_d      = 1'b0;
      stuck_d      = stuck_q;
      level_d      = level_q;
      start        = 1'b0;
      close        = 1'b0;
      expire       = 1'b0;

      if (tick) begin
         unique case (state_q)
            IDLE, STUCK: begin
               if (rise) begin
                  start = 1'b1;
               end else if (state_q == IDLE) begin
                  no_edge_d = no_edge_inc;
                  expire    = (no_edge_inc == TO_VAL);
               end
            end
            MEASURE: begin
               if (rise) begin
                  close = 1'b1;
               end else begin
                  if (period_cnt_q != CNT_MAX)
                     period_cnt_d = period_cnt_q + 1'b1;
                  if (sample && high_cnt_q != CNT_MAX)
                     high_cnt_d = high_cnt_q + 1'b1;
                  no_edge_d = no_edge_inc;
                  expire    = (no_edge_inc == TO_VAL);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (start || close) begin
         state_d      = MEASURE;
         period_cnt_d = CNTW'(1);
         high_cnt_d   = CNTW'(1);
         no_edge_d    = '0;
      end

      if (start) begin
         stuck_d = 1'b0;
         acc_d   = '0;
         n_d     = '0;
      end

      if (close) begin
         acc_d = acc_sum;
         n_d   = n_q + 1'b1;
         if (n_q == N_LAST) begin
            duty_d   = acc_sum;
            period_d = period_cnt_q;
            stuck_d  = 1'b0;
            valid_d  = 1'b1;
            acc_d    = '0;
            n_d      = '0;
         end
      end

      if (expire) begin
         state_d  = STUCK;
         stuck_d  = 1'b1;
         level_d  = sample;
         duty_d   = {AW{sample}};
         period_d = '0;
         valid_d  = 1'b1;
         acc_d    = '0;
         n_d      = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= IDLE;
         sync_q       <= '0;
         presc_q      <= '0;
         prev_q       <= 1'b0;
         period_cnt_q <= '0;
         high_cnt_q   <= '0;
         no_edge_q    <= '0;
         acc_q        <= '0;
         n_q          <= '0;
         duty_q       <= '0;
         period_q     <= '0;
         valid_q      <= 1'b0;
         stuck_q      <= 1'b0;
         level_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         presc_q      <= presc_d;
         prev_q       <= prev_d;
         period_cnt_q <= period_cnt_d;
         high_cnt_q   <= high_cnt_d;
         no_edge_q    <= no_edge_d;
         acc_q        <= acc_d;
         n_q          <= n_d;
         duty_q       <= duty_d;
         period_q     <= period_d;
         valid_q      <= valid_d;
         stuck_q      <= stuck_d;
         level_q      <= level_d;
      end
   end

   assign duty_o        = duty_q;
   assign period_o      = period_q;
   assign valid_o       = valid_q;
   assign stuck_o       = stuck_q;
   assign stuck_level_o = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: a period-level model predicts every published result,
// and a per-cycle compare process checks the DUT outputs against it.
module tb_pwm_capture;

   localparam int DIV  = 2;
   localparam int CNTW = 9;
   localparam int AVG  = 4;
   localparam int TO   = 512;
   localparam int AW   = CNTW + AVG;
   localparam int CMAX = (1 << CNTW) - 1;
   localparam int NPER = 1 << AVG;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            pwm_i = 1'b0;
   logic [AW-1:0]   duty_o;
   logic [CNTW-1:0] period_o;
   logic            valid_o;
   logic            stuck_o;
   logic            stuck_level_o;

   pwm_capture #(
      .DIV(DIV),
      .CNTW(CNTW),
      .AVG_LOG2(AVG),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .pwm_i(pwm_i),
      .duty_o(duty_o),
      .period_o(period_o),
      .valid_o(valid_o),
      .stuck_o(stuck_o),
      .stuck_level_o(stuck_level_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int trig;
      bit v;
      int duty;
      int per;
      bit st;
      bit lv;
   } ev_t;

   ev_t evq[$];
   int  cyc = 0;
   int  n_chk = 0;
   int  n_fail = 0;

   // model state
   int  m_mode;
   bit  m_last;
   int  m_quiet, m_run, m_high, m_acc, m_n, mt;
   int  m_duty, m_per;
   bit  m_st, m_lv;

   // compare-side state
   bit  chk_en = 1'b0;
   bit  lat_ok = 1'b0;
   int  lat = 0;
   ev_t cur;
   bit  e_v;
   int  e_duty, e_per;
   bit  e_st, e_lv;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic push(input int trig, input bit v);
      evq.push_back(ev_t'{trig, v, m_duty, m_per, m_st, m_lv});
   endtask

   // Segment of nt ticks at constant level; a 0->1 step is a rising edge.
   task automatic model_seg(input bit lvl, input int nt);
      int rem;
      int idx0;
      int k;
      rem  = nt;
      idx0 = 0;
      if (lvl && !m_last) begin
         if (m_mode == 1) begin
            m_acc += (m_high > CMAX) ? CMAX : m_high;
            m_n++;
            if (m_n == NPER) begin
               m_duty = m_acc;
               m_per  = (m_run > CMAX) ? CMAX : m_run;
               m_st   = 1'b0;
               push(mt, 1'b1);
               m_acc = 0;
               m_n   = 0;
            end
         end else begin
            if (m_mode == 2) begin
               m_st = 1'b0;
               push(mt, 1'b0);
            end
            m_mode = 1;
            m_acc  = 0;
            m_n    = 0;
         end
         m_run   = 1;
         m_high  = 1;
         m_quiet = 0;
         rem     = nt - 1;
         idx0    = 1;
      end
      if (m_mode != 2 && m_quiet + rem >= TO) begin
         k      = TO - m_quiet;
         m_duty = lvl ? (1 << AW) - 1 : 0;
         m_per  = 0;
         m_st   = 1'b1;
         m_lv   = lvl;
         push(mt + (idx0 + k - 1) * DIV, 1'b1);
         m_mode = 2;
         m_acc  = 0;
         m_n    = 0;
      end
      m_quiet += rem;
      m_run   += rem;
      if (lvl) m_high += rem;
      m_last = lvl;
      mt += nt * DIV;
   endtask

   task automatic drive(input bit lvl, input int nt);
      for (int i = 0; i < nt; i++) begin
         pwm_i = lvl;
         repeat (DIV) @(negedge clk);
      end
   endtask

   task automatic seg(input bit lvl, input int nt);
      model_seg(lvl, nt);
      drive(lvl, nt);
   endtask

   task automatic pwm_period(input int p, input int h);
      seg(1'b1, h);
      seg(1'b0, p - h);
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      @(negedge clk);
      rstn = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         pwm_i = ~pwm_i;
      end
      check("rst_duty", 32'(duty_o), 0);
      check("rst_period", 32'(period_o), 0);
      check("rst_valid", 32'(valid_o), 0);
      check("rst_stuck", 32'(stuck_o), 0);
      check("rst_level", 32'(stuck_level_o), 0);
      pwm_i = 1'b0;
      @(negedge clk);
      rstn    = 1'b1;
      m_mode  = 0;
      m_last  = 1'b0;
      m_quiet = 0;
      m_run   = 0;
      m_high  = 0;
      m_acc   = 0;
      m_n     = 0;
      m_duty  = 0;
      m_per   = 0;
      m_st    = 1'b0;
      m_lv    = 1'b0;
      evq.delete();
      lat_ok  = 1'b0;
      e_duty  = 0;
      e_per   = 0;
      e_st    = 1'b0;
      e_lv    = 1'b0;
      mt      = cyc;
      chk_en  = 1'b1;
   endtask

   // Latency from driven tick to output update is learnt on the first
   // result, then every later update must land exactly that far after its tick.
   always @(negedge clk) begin
      if (chk_en) begin
         e_v = 1'b0;
         if (evq.size() > 0) begin
            if (!lat_ok && valid_o === 1'b1 && evq[0].v) begin
               lat    = cyc - evq[0].trig;
               lat_ok = 1'b1;
               n_chk++;
               if (lat < 1 || lat > 3 * DIV + 4) begin
                  n_fail++;
                  $display("FAIL latency: got %0d expected 1..%0d", lat, 3 * DIV + 4);
               end
            end
            if (lat_ok && cyc == evq[0].trig + lat) begin
               cur    = evq.pop_front();
               e_v    = cur.v;
               e_duty = cur.duty;
               e_per  = cur.per;
               e_st   = cur.st;
               e_lv   = cur.lv;
            end
         end
         n_chk++;
         if (valid_o !== e_v || duty_o !== AW'(e_duty) ||
             period_o !== CNTW'(e_per) || stuck_o !== e_st ||
             stuck_level_o !== e_lv) begin
            n_fail++;
            $display("FAIL outputs cyc=%0d: got v=%b d=%0d p=%0d s=%b l=%b, expected v=%b d=%0d p=%0d s=%b l=%b",
                     cyc, valid_o, duty_o, period_o, stuck_o, stuck_level_o,
                     e_v, e_duty, e_per, e_st, e_lv);
         end
      end
   end

   initial begin
      do_reset();
      seg(1'b0, 100);

      for (int i = 0; i < 16; i++) pwm_period(256, 64);

      for (int i = 0; i < 17; i++) begin
         pwm_period(256, (i % 2 == 1) ? 101 : 100);
         if (i == 0) begin
            check("clean_duty", 32'(m_duty), 1024);
            check("clean_period", 32'(m_per), 256);
         end
      end
      check("dither_duty", 32'(m_duty), 1608);
      check("dither_period", 32'(m_per), 256);

      seg(1'b1, 600);
      check("hold1_duty", 32'(m_duty), 8191);
      check("hold1_period", 32'(m_per), 0);
      check("hold1_stuck", 32'(m_st), 1);
      check("hold1_level", 32'(m_lv), 1);

      seg(1'b0, 10);
      seg(1'b1, 64);
      check("unstuck", 32'(m_st), 0);
      seg(1'b0, 600);
      check("hold0_duty", 32'(m_duty), 0);
      check("hold0_stuck", 32'(m_st), 1);
      check("hold0_level", 32'(m_lv), 0);

      for (int i = 0; i < 16; i++) pwm_period(256, 128);

      for (int i = 0; i < 17; i++) begin
         if (i == 4) begin
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
            model_seg(1'b1, 64);
            drive(1'b1, 30);
            drive(1'b0, 1);
            drive(1'b1, 33);
`else
            seg(1'b1, 30);
            seg(1'b0, 1);
            seg(1'b1, 33);
`endif
            seg(1'b0, 192);
         end else begin
            pwm_period(256, 64);
         end
         if (i == 0) begin
            check("recover_duty", 32'(m_duty), 2048);
            check("recover_period", 32'(m_per), 256);
         end
      end
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      check("glitch_duty", 32'(m_duty), 1024);
`else
      check("glitch_duty", 32'(m_duty), 959);
`endif
      check("glitch_period", 32'(m_per), 256);

      for (int i = 0; i < 5; i++) pwm_period(256, 64);
      check("pending_before_reset", 32'(evq.size()), 0);
      do_reset();
      seg(1'b0, 100);
      check("pending_at_end", 32'(evq.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Receive-side counterpart of the analog PWM outputs: samples an external PWM waveform and recovers its duty cycle as a digital word. Counts high ticks and period ticks per PWM period and accumulates high ticks over 2^AVG_LOG2 periods for extra resolution. Publishes a new result with a one-clock valid strobe. Sits in the housekeeping/IO area and feeds loopback tests and external PWM-sourced setpoints.

Parameters:
DIV, 16, clk cycles per sample tick (must match transmitter prescaler), >=2
CNTW, 9, per-period tick counter width (holds 256-tick period)
AVG_LOG2, 4, log2 of periods accumulated per result
TIMEOUT, 512, ticks without a rising edge before the stuck condition, < 2^CNTW+... (fits in CNTW+1 bits)

Ports:
clk  in  1  system clock
rstn  in  1  reset, synchronous, active-low
pwm_i  in  1  asynchronous PWM input
duty_o  out  CNTW+AVG_LOG2  sum of high ticks over last 2^AVG_LOG2 periods
period_o  out  CNTW  tick length of last completed period
valid_o  out  1  one-clk pulse when duty_o/period_o update
stuck_o  out  1  no rising edge within TIMEOUT ticks
stuck_level_o  out  1  sampled level while stuck

Behaviour:
- Reset (rstn=0 at posedge clk): all outputs 0, prescaler/counters/accumulator 0, synchronizer 0, state IDLE. Reset mid-measurement discards partial data; no valid_o is issued for it.
- pwm_i passes a 2-FF synchronizer (s). Prescaler counts 0..DIV-1; tick when it equals DIV-1. All sampling and counting happens only on tick cycles.
- On a tick: sample = s; rise = sample & ~prev_sample; prev_sample <= sample.
- States: IDLE, MEASURE, STUCK.
- IDLE: wait for rise. On rise: period_cnt=1, high_cnt=1, acc=0, n=0, go to MEASURE. The idle-tick counter still runs and enters STUCK after TIMEOUT ticks.
- MEASURE, tick without rise: period_cnt+1 and high_cnt+sample, both saturating at 2^CNTW-1. no_edge_cnt+1.
- MEASURE, tick with rise: the completed period is P=period_cnt, H=high_cnt. Set acc<=acc+H and n<=n+1. Restart period_cnt=1, high_cnt=1, no_edge_cnt=0.
  - If n==2^AVG_LOG2-1: on the next clk set duty_o<=acc+H, period_o<=P, stuck_o<=0, valid_o=1 for exactly one clk; acc<=0, n<=0.
- Latency: valid_o asserts 1 clk after the tick that detects the closing rising edge, plus 2 clk synchronizer delay from pin.
- Timeout: when no_edge_cnt reaches TIMEOUT in IDLE or MEASURE, go to STUCK. Set stuck_o=1 and stuck_level_o=sample. Set duty_o to all-ones if sample=1, else 0. Set period_o=0 and pulse valid_o once. Clear acc and n.
- STUCK: outputs hold. On rise: clear stuck_o, go to MEASURE with the same init as IDLE. The first valid result comes after a full 2^AVG_LOG2 periods.
- Saturation: duty_o never wraps. Accumulator width is CNTW+AVG_LOG2, and saturated per-period counts are summed as-is.
- valid_o is never asserted for two consecutive clks.

Optional Feature:
PWM_CAPTURE_GLITCH_FILTER_EN
- Defined: sample = majority of the last 3 tick samples of s. This adds 2 ticks of edge delay, with period/high counts unchanged for clean input, and rejects single-tick glitches.
- Undefined: sample = s at tick, with no filtering.

Test Plan:
- Reset: hold rstn=0 for 5 clk while pwm_i toggles -> all outputs 0, and no valid_o within 200 clk after release while pwm_i=0.
- Clean PWM, DIV=16, period 256 ticks, high 64 ticks, 20 periods -> first valid_o after 17th rising edge; duty_o=1024, period_o=256, stuck_o=0.
- Dithered input alternating high 100/101 ticks per period, period 256 -> duty_o=1608 (8x100+8x101), period_o=256.
- pwm_i held 1 for 600 ticks after measuring -> exactly one valid_o at tick 512 after last rise; stuck_o=1, stuck_level_o=1, duty_o=8191, period_o=0. Held 0 instead -> duty_o=0, stuck_level_o=0.
- Recovery: from STUCK apply clean 256/128 PWM -> stuck_o clears on first rise; next valid_o duty_o=2048.
- Glitch: one-tick 0 pulse inside high phase, macro defined -> duty_o unchanged (1024 case). Macro undefined -> extra rising edge shortens period and changes the result.
